// File: rtl/bow_rx_frame_buf.sv
// BoW receive framer: locks on a sync word, captures fixed-length frames into two
// ping-pong banks and drains completed frames as a valid/ready stream with SOF/EOF.
module bow_rx_frame_buf #(
  parameter int                DATA_W    = 16,
  parameter int                FRAME_LEN = 32,
  parameter logic [DATA_W-1:0] SYNC_WORD = 16'h7FFE,
  parameter int                SETUP_CYC = 8
) (
  input  logic              clk_pos,
  input  logic              preset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_fec,
  input  logic              rx_aux,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_fec,
  output logic              out_aux,
  output logic              out_sof,
  output logic              out_eof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        drop_cnt
);

  localparam int IDX_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int AW     = $clog2(2 * FRAME_LEN);
  localparam int WORD_W = DATA_W + 2;
  localparam int SET_W  = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETUP_CYC - 1);

  typedef enum logic [1:0] {
    ST_SETTLE  = 2'd0,
    ST_HUNT    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DROP    = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [SET_W-1:0]   r_settle_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_wr_bank;
  logic               r_rd_bank;
  logic               r_full [2];
  logic [IDX_W-1:0]   r_rd_idx;
  logic               r_fetched_all;
  logic               r_out_valid;
  logic               r_out_sof;
  logic               r_out_eof;
  logic [WORD_W-1:0]  r_rd_word;
  logic               r_overflow;
  logic [15:0]        r_frame_cnt;
  logic [7:0]         r_drop_cnt;
  logic [WORD_W-1:0]  r_mem [2*FRAME_LEN];

  logic               w_cap_we;
  logic               w_cap_done;
  logic               w_drop;
  logic               w_wr_free;
  logic               w_xfer;
  logic               w_eof_xfer;
  logic               w_load_ok;
  logic               w_fetch_bank;
  logic               w_load;
  logic [AW-1:0]      w_wr_addr;
  logic [AW-1:0]      w_rd_addr;

  // A bank whose EOF is accepted this very cycle is already reusable.
  assign w_wr_free = ~r_full[r_wr_bank] | (w_eof_xfer & (r_rd_bank == r_wr_bank));

  assign w_wr_addr = AW'(r_idx) + (r_wr_bank ? AW'(FRAME_LEN) : AW'(0));

  always_ff @(posedge clk_pos) begin
    if (preset) begin
      r_state <= ST_SETTLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cap_we     = 1'b0;
    w_cap_done   = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      ST_SETTLE: begin
        if (rx_valid && (r_settle_cnt == SET_LAST)) w_state_next = ST_HUNT;
      end
      ST_HUNT: begin
        if (rx_valid && (rx_data == SYNC_WORD)) begin
          if (w_wr_free) begin
            w_state_next = ST_CAPTURE;
          end else begin
            w_state_next = ST_DROP;
            w_drop       = 1'b1;
          end
        end
      end
      ST_CAPTURE: begin
        if (rx_valid) begin
          w_cap_we = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_cap_done   = 1'b1;
            w_state_next = ST_HUNT;
          end
        end
      end
      ST_DROP: begin
        if (rx_valid && (r_idx == LAST_IDX)) w_state_next = ST_HUNT;
      end
      default: w_state_next = ST_SETTLE;
    endcase
  end

  always_ff @(posedge clk_pos) begin
    if (preset) begin
      r_settle_cnt <= '0;
      r_idx        <= '0;
      r_wr_bank    <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_overflow <= w_drop;
      if ((r_state == ST_SETTLE) && rx_valid && (r_settle_cnt != SET_LAST)) begin
        r_settle_cnt <= r_settle_cnt + 1'b1;
      end
      if (r_state == ST_HUNT) begin
        r_idx <= '0;
      end else if (((r_state == ST_CAPTURE) || (r_state == ST_DROP)) && rx_valid) begin
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      end
      if (w_cap_done) r_wr_bank <= ~r_wr_bank;
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_pos) begin
    if (w_cap_we) r_mem[w_wr_addr] <= {rx_data, rx_fec, rx_aux};
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      always_ff @(posedge clk_pos) begin
        if (preset) begin
          r_full[gi] <= 1'b0;
        end else if (w_cap_done && (r_wr_bank == 1'(gi))) begin
          r_full[gi] <= 1'b1;
        end else if (w_eof_xfer && (r_rd_bank == 1'(gi))) begin
          r_full[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Output slot refills when empty or consumed; on EOF it pulls word 0 of the other bank.
  assign w_xfer       = r_out_valid & out_ready;
  assign w_eof_xfer   = w_xfer & r_out_eof;
  assign w_load_ok    = ~r_out_valid | out_ready;
  assign w_fetch_bank = w_eof_xfer ? ~r_rd_bank : r_rd_bank;
  assign w_load       = w_load_ok & r_full[w_fetch_bank] & (w_eof_xfer | ~r_fetched_all);
  assign w_rd_addr    = AW'(r_rd_idx) + (w_fetch_bank ? AW'(FRAME_LEN) : AW'(0));

  always_ff @(posedge clk_pos) begin
    if (w_load) r_rd_word <= r_mem[w_rd_addr];
  end

  always_ff @(posedge clk_pos) begin
    if (preset) begin
      r_out_valid   <= 1'b0;
      r_out_sof     <= 1'b0;
      r_out_eof     <= 1'b0;
      r_rd_idx      <= '0;
      r_fetched_all <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      if (w_load) begin
        r_out_valid   <= 1'b1;
        r_out_sof     <= (r_rd_idx == '0);
        r_out_eof     <= (r_rd_idx == LAST_IDX);
        r_rd_idx      <= (r_rd_idx == LAST_IDX) ? '0 : r_rd_idx + 1'b1;
        r_fetched_all <= (r_rd_idx == LAST_IDX);
      end else begin
        if (w_xfer) begin
          r_out_valid <= 1'b0;
          r_out_sof   <= 1'b0;
          r_out_eof   <= 1'b0;
        end
        if (w_eof_xfer) r_fetched_all <= 1'b0;
      end
      if (w_eof_xfer) begin
        r_rd_bank   <= ~r_rd_bank;
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign rx_ready  = ~preset & (r_state != ST_SETTLE);
  assign {out_data, out_fec, out_aux} = r_out_valid ? r_rd_word : '0;
  assign out_sof   = r_out_sof;
  assign out_eof   = r_out_eof;
  assign out_valid = r_out_valid;
  assign overflow  = r_overflow;
  assign frame_cnt = r_frame_cnt;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_bow_rx_frame_buf.sv
// Directed bench for bow_rx_frame_buf: settle/lock, ping-pong drain, drops,
// same-cycle bank reuse and mid-frame resets, checked against a word scoreboard.
module tb_bow_rx_frame_buf;

  localparam int          FL   = 32;
  localparam logic [15:0] SYNC = 16'h7FFE;

  logic        clk_pos   = 1'b0;
  logic        preset    = 1'b1;
  logic [15:0] rx_data   = '0;
  logic        rx_fec    = 1'b0;
  logic        rx_aux    = 1'b0;
  logic        rx_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic        rx_ready;
  logic [15:0] out_data;
  logic        out_fec, out_aux, out_sof, out_eof, out_valid, overflow;
  logic [15:0] frame_cnt;
  logic [7:0]  drop_cnt;
  logic [46:0] all_outs;

  always #5 clk_pos = ~clk_pos;

  bow_rx_frame_buf #(
    .DATA_W(16), .FRAME_LEN(FL), .SYNC_WORD(SYNC), .SETUP_CYC(8)
  ) dut (
    .clk_pos(clk_pos), .preset(preset),
    .rx_data(rx_data), .rx_fec(rx_fec), .rx_aux(rx_aux), .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .out_data(out_data), .out_fec(out_fec), .out_aux(out_aux),
    .out_sof(out_sof), .out_eof(out_eof), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  assign all_outs = {rx_ready, out_data, out_fec, out_aux, out_sof, out_eof,
                     out_valid, overflow, frame_cnt, drop_cnt};

  int          n_cmp = 0;
  int          n_err = 0;
  logic [17:0] exp_q[$];
  logic [17:0] fw [FL];
  logic [17:0] m_exp;
  logic [17:0] a0;
  int          pos = 0;
  int          ovf_cnt = 0;
  int          ovf0 = 0;
  int          n_frames_seen = 0;
  bit          rand_rdy = 1'b0;
  bit          gap_en = 1'b0;
  bit          found = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: one negedge+1 sample predicts the transfer at the next posedge.
  initial begin
    forever begin
      @(negedge clk_pos);
      #1;
      if (preset) begin
        pos = 0;
      end else begin
        if (overflow) ovf_cnt++;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_word", 64'({out_sof, out_eof, out_data, out_fec, out_aux}),
                     64'hDEAD_BEEF);
          end else begin
            m_exp = exp_q.pop_front();
            check_eq("out_word", 64'({out_sof, out_eof, out_data, out_fec, out_aux}),
                     64'({pos == 0, pos == FL - 1, m_exp}));
            if (pos == FL - 1) begin
              n_frames_seen++;
              $display("frame %0d delivered at %0t", n_frames_seen, $time);
            end
            pos = (pos == FL - 1) ? 0 : pos + 1;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk_pos);
    if (rand_rdy) out_ready = 1'($urandom_range(1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      rx_valid = 1'b0;
    end
  endtask

  task automatic send(input logic [17:0] w);
    if (gap_en && ($urandom_range(3) == 0)) begin
      tick();
      rx_valid = 1'b0;
      rx_data  = SYNC;
    end
    tick();
    {rx_data, rx_fec, rx_aux} = w;
    rx_valid = 1'b1;
  endtask

  task automatic do_reset();
    tick();
    preset   = 1'b1;
    rx_valid = 1'b0;
    exp_q.delete();
    tick();
    tick();
    preset = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 8; i++) send({16'h1000 + 16'(i), 2'b00});
  endtask

  task automatic build(input logic [7:0] tag);
    for (int i = 0; i < FL; i++) fw[i] = {tag, 8'(i), 1'($urandom_range(1)), 1'($urandom_range(1))};
  endtask

  task automatic send_frame(input bit push);
    send({SYNC, 2'b00});
    for (int i = 0; i < FL; i++) send(fw[i]);
    if (push) for (int i = 0; i < FL; i++) exp_q.push_back(fw[i]);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 4000 && (exp_q.size() != 0 || out_valid); i++) idle(1);
    check_eq(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    // T1: settle, lock, single frame straight through
    do_reset();
    check_eq("rst_outs", 64'(all_outs), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send({16'h1000 + 16'(i), 2'b00});
    idle(1);
    check_eq("t1_settle7_ready", 64'(rx_ready), 64'd0);
    send({16'h1007, 2'b00});
    idle(1);
    check_eq("t1_settle8_ready", 64'(rx_ready), 64'd1);
    for (int i = 0; i < FL; i++) fw[i] = {16'(i), i[0], i[1]};
    send_frame(1'b1);
    wait_drain("t1_drain");
    check_eq("t1_frame_cnt", 64'(frame_cnt), 64'd1);
    check_eq("t1_drop_cnt", 64'(drop_cnt), 64'd0);

    // T2: sync during settle must not lock
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send({16'h2000 + 16'(i), 2'b00});
    send({SYNC, 2'b00});
    for (int i = 0; i < 4; i++) send({16'h2010 + 16'(i), 2'b00});
    idle(1);
    check_eq("t2_ready", 64'(rx_ready), 64'd1);
    for (int i = 0; i < 40; i++) send({16'h0100 + 16'(i), 2'b01});
    idle(10);
    check_eq("t2_no_valid", 64'(out_valid), 64'd0);
    check_eq("t2_frame_cnt", 64'(frame_cnt), 64'd0);

    // T3: stalled sink, third frame dropped, then drain and recover
    do_reset();
    settle();
    ovf0 = ovf_cnt;
    out_ready = 1'b0;
    build(8'hA0);
    a0 = fw[0];
    send_frame(1'b1);
    build(8'hB0);
    send_frame(1'b1);
    build(8'hC0);
    send_frame(1'b0);
    idle(4);
    check_eq("t3_ovf_pulses", 64'(ovf_cnt - ovf0), 64'd1);
    check_eq("t3_drop_cnt", 64'(drop_cnt), 64'd1);
    check_eq("t3_hold", 64'({out_valid, out_sof, out_eof, out_data, out_fec, out_aux}),
             64'({3'b110, a0}));
    out_ready = 1'b1;
    wait_drain("t3_drain");
    check_eq("t3_frame_cnt", 64'(frame_cnt), 64'd2);
    build(8'hD3);
    send_frame(1'b1);
    wait_drain("t3_after_drop");
    check_eq("t3_frame_cnt_after", 64'(frame_cnt), 64'd3);

    // T4: random backpressure and input gaps, sync values embedded as data
    do_reset();
    settle();
    ovf0 = ovf_cnt;
    rand_rdy = 1'b1;
    gap_en = 1'b1;
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < FL; i++)
        fw[i] = {16'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1))};
      fw[5][17:2]  = SYNC;
      fw[17][17:2] = SYNC;
      if (f % 2 == 1) fw[0][17:2] = SYNC;
      for (int w = 0; w < 2000 && exp_q.size() > FL; w++) idle(1);
      send_frame(1'b1);
    end
    wait_drain("t4_drain");
    rand_rdy = 1'b0;
    gap_en = 1'b0;
    out_ready = 1'b1;
    check_eq("t4_frame_cnt", 64'(frame_cnt), 64'd20);
    check_eq("t4_drop_cnt", 64'(drop_cnt), 64'd0);
    check_eq("t4_ovf_pulses", 64'(ovf_cnt - ovf0), 64'd0);

    // T5: sync lands on the cycle the full write bank's EOF is accepted
    do_reset();
    settle();
    ovf0 = ovf_cnt;
    out_ready = 1'b0;
    build(8'h51);
    send_frame(1'b1);
    build(8'h52);
    send_frame(1'b1);
    build(8'h53);
    idle(2);
    out_ready = 1'b1;
    found = 1'b0;
    for (int w = 0; w < 200 && !found; w++) begin
      tick();
      rx_valid = 1'b0;
      if (out_valid && out_eof) begin
        found    = 1'b1;
        rx_data  = SYNC;
        rx_fec   = 1'b0;
        rx_aux   = 1'b0;
        rx_valid = 1'b1;
      end
    end
    check_eq("t5_eof_seen", 64'(found), 64'd1);
    for (int i = 0; i < FL; i++) send(fw[i]);
    for (int i = 0; i < FL; i++) exp_q.push_back(fw[i]);
    wait_drain("t5_drain");
    check_eq("t5_ovf_pulses", 64'(ovf_cnt - ovf0), 64'd0);
    check_eq("t5_drop_cnt", 64'(drop_cnt), 64'd0);
    check_eq("t5_frame_cnt", 64'(frame_cnt), 64'd3);

    // T6: reset mid-capture and mid-drain
    do_reset();
    settle();
    out_ready = 1'b1;
    build(8'h61);
    send({SYNC, 2'b00});
    for (int i = 0; i < 10; i++) send(fw[i]);
    tick();
    preset   = 1'b1;
    rx_valid = 1'b0;
    exp_q.delete();
    tick();
    check_eq("t6_rst1_outs", 64'(all_outs), 64'd0);
    preset = 1'b0;
    settle();
    idle(60);
    check_eq("t6_no_stale1", 64'({out_valid, frame_cnt}), 64'd0);
    out_ready = 1'b0;
    build(8'h62);
    send_frame(1'b1);
    idle(3);
    out_ready = 1'b1;
    for (int w = 0; w < 200 && pos < 6; w++) idle(1);
    tick();
    preset   = 1'b1;
    rx_valid = 1'b0;
    exp_q.delete();
    tick();
    check_eq("t6_rst2_outs", 64'(all_outs), 64'd0);
    preset = 1'b0;
    settle();
    idle(60);
    check_eq("t6_no_stale2", 64'({out_valid, frame_cnt, drop_cnt}), 64'd0);
    build(8'h63);
    send_frame(1'b1);
    wait_drain("t6_drain");
    check_eq("t6_frame_cnt", 64'(frame_cnt), 64'd1);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
